// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode, RV32I decode constants and decoded-word type
// Purpose: types, constants and small helpers shared by alu_op_decode and alu_issue_stage.
// Ports: none (package).
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    alu_op_e     sel;
    logic [4:0]  shift_amt;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        illegal;
  } alu_issue_t;

  // Idle/bubble word: ADD with zero operands.
  localparam alu_issue_t ISSUE_IDLE = '{
    sel: ALU_ADD, shift_amt: 5'd0, data_a: 32'd0, data_b: 32'd0, illegal: 1'b0
  };

  // Base (funct7 = 0000000) operation selected by funct3.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3);
    case (f3)
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational RV32I OP/OP-IMM decode into an ALU issue word
// Purpose: maps instruction + register operands to ALU opcode, shift amount and operands.
// Ports:
//   instr     in  32  instruction word
//   rs1_data  in  32  register-file read port 1
//   rs2_data  in  32  register-file read port 2
//   dec       out     decoded alu_issue_t (illegal words become an ADD 0,0 bubble)
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output alu_issue_t  dec
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic        is_imm;
  logic [31:0] opnd_b;
  logic [4:0]  shamt_src;
  alu_op_e     op;
  logic        legal;
  logic        unused_fields;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign is_imm    = (opcode == OPC_OP_IMM);
  assign opnd_b    = is_imm ? {{20{instr[31]}}, instr[31:20]} : rs2_data;
  assign shamt_src = is_imm ? instr[24:20] : rs2_data[4:0];

  // Register specifiers are resolved upstream; only the data arrives here.
  assign unused_fields = ^{instr[19:15], instr[11:7]};

  always_comb begin
    op    = ALU_ADD;
    legal = 1'b0;
    if (opcode == OPC_OP) begin
      if (funct7 == F7_BASE) begin
        op    = f3_to_op(funct3);
        legal = 1'b1;
      end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
        op    = ALU_SUB;
        legal = 1'b1;
      end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
        op    = ALU_SRA;
        legal = 1'b1;
      end
    end else if (is_imm) begin
      // Upper immediate bits are only constrained for the shift forms.
      case (funct3)
        3'b001: begin
          if (funct7 == F7_BASE) begin
            op    = ALU_SLL;
            legal = 1'b1;
          end
        end
        3'b101: begin
          if (funct7 == F7_BASE) begin
            op    = ALU_SRL;
            legal = 1'b1;
          end else if (funct7 == F7_ALT) begin
            op    = ALU_SRA;
            legal = 1'b1;
          end
        end
        default: begin
          op    = f3_to_op(funct3);
          legal = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    dec = ISSUE_IDLE;
    if (!legal) begin
      dec.illegal = 1'b1;
    end else begin
      dec.sel = op;
      if (is_shift(op)) begin
        dec.data_a    = rs1_data;
        dec.shift_amt = shamt_src;
      end else if (op == ALU_SUB) begin
        // The ALU computes b - a, so the subtrahend goes on port a.
        dec.data_a = opnd_b;
        dec.data_b = rs1_data;
      end else begin
        dec.data_a = rs1_data;
        dec.data_b = opnd_b;
      end
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered ALU issue stage with valid/ready handshake
// Purpose: decodes OP/OP-IMM words, registers ALU controls one stage ahead of the ALU,
//   flags and counts unsupported encodings.
// Optional feature macro: ALU_ISSUE_SKID_EN (1-entry skid buffer, registered in_ready).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake; instr, rs1_data, rs2_data payload
//   out_valid/out_ready      downstream handshake
//   alu_sel, shift_amt       ALU opcode and shift amount
//   data_a, data_b           ALU operands
//   illegal                  current output word is an unsupported encoding
//   illegal_cnt              saturating count of accepted illegal words
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output alu_op_e          alu_sel,
  output logic [4:0]       shift_amt,
  output logic [31:0]      data_a,
  output logic [31:0]      data_b,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  alu_issue_t dec;
  alu_issue_t out_q;
  logic       in_fire;

  alu_op_decode u_decode (
    .instr    (instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dec      (dec)
  );

  assign in_fire = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
  alu_issue_t skid_q;
  logic       skid_valid;
  logic       skid_valid_n;
  logic       in_ready_q;
  logic       out_free;

  assign out_free = !out_valid || out_ready;
  assign in_ready = in_ready_q;

  // A full skid can only drain; an empty skid fills when a word arrives into a stall.
  always_comb begin
    skid_valid_n = skid_valid;
    if (skid_valid) begin
      skid_valid_n = !out_free;
    end else begin
      skid_valid_n = in_fire && !out_free;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_q      <= ISSUE_IDLE;
      skid_valid <= 1'b0;
      skid_q     <= ISSUE_IDLE;
      in_ready_q <= 1'b0;
    end else begin
      skid_valid <= skid_valid_n;
      in_ready_q <= !skid_valid_n;
      if (in_fire && !out_free) begin
        skid_q <= dec;
      end
      if (out_free) begin
        if (skid_valid) begin
          out_q     <= skid_q;
          out_valid <= 1'b1;
        end else if (in_fire) begin
          out_q     <= dec;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end
`else
  logic out_fire;

  assign out_fire = out_valid && out_ready;
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= ISSUE_IDLE;
    end else if (in_fire) begin
      out_q     <= dec;
      out_valid <= 1'b1;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (in_fire && dec.illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign alu_sel   = out_q.sel;
  assign shift_amt = out_q.shift_amt;
  assign data_a    = out_q.data_a;
  assign data_b    = out_q.data_b;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  typedef logic [73:0] word_t;   // {sel, shift_amt, data_a, data_b, illegal}

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_sel;
  logic [4:0]  shift_amt;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        illegal;
  logic [15:0] illegal_cnt;

  always #5 clk = ~clk;

  alu_issue_stage #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_sel     (alu_sel),
    .shift_amt   (shift_amt),
    .data_a      (data_a),
    .data_b      (data_b),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  int          tests = 0;
  int          fails = 0;
  word_t       q[$];
  logic [15:0] cnt_m;
  bit          lat_chk;
  bit          dir_en;
  bit          last_inf;
  word_t       dir_exp;
  // funct3 -> opcode number for the funct7=0 forms (ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND)
  int          f3ops[8] = '{0, 7, 2, 3, 6, 8, 5, 4};

  task automatic check(input string tag, input word_t obs, input word_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic word_t pk_out();
    return {alu_sel, shift_amt, data_a, data_b, illegal};
  endfunction

  function automatic word_t model(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    int          op;
    bit          ok;
    bit          imm;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] b;
    logic [4:0]  sh;
    f7  = ins[31:25];
    f3  = ins[14:12];
    imm = (ins[6:0] == 7'b0010011);
    ok  = 1'b0;
    op  = f3ops[f3];
    if (ins[6:0] == 7'b0110011) begin
      if (f7 == 7'h00) ok = 1'b1;
      else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
        ok = 1'b1;
        op = op + 1;
      end
    end else if (imm) begin
      if (f3 != 3'd1 && f3 != 3'd5) ok = 1'b1;
      else if (f7 == 7'h00) ok = 1'b1;
      else if (f7 == 7'h20 && f3 == 3'd5) begin
        ok = 1'b1;
        op = 9;
      end
    end
    if (!ok) return {4'd0, 5'd0, 32'd0, 32'd0, 1'b1};
    b  = imm ? {{20{ins[31]}}, ins[31:20]} : r2;
    sh = imm ? ins[24:20] : r2[4:0];
    if (op >= 7) return {op[3:0], sh, r1, 32'd0, 1'b0};
    if (op == 1) return {4'd1, 5'd0, b, r1, 1'b0};
    return {op[3:0], 5'd0, r1, b, 1'b0};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd3, 7'b0010011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0, 1:    r[6:0] = 7'b0110011;
      2, 3:    r[6:0] = 7'b0010011;
      4:       r[6:0] = 7'b1100011;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0, 1:    r[31:25] = 7'h00;
      2:       r[31:25] = 7'h20;
      default: ;
    endcase
    return r;
  endfunction

  // One clock: observe at negedge against the scoreboard, then advance to posedge+1.
  task automatic cycle();
    bit    inf;
    bit    outf;
    word_t w;
    @(negedge clk);
    check("illegal_cnt", 74'(illegal_cnt), 74'(cnt_m));
    check("out_valid_vs_pending", 74'(out_valid), 74'(q.size() > 0));
    if (lat_chk) check("latency_out_valid", 74'(out_valid), 74'(1));
    lat_chk = 1'b0;
    if (dir_en) begin
      check("directed_word", pk_out(), dir_exp);
      dir_en = 1'b0;
    end
    inf  = in_valid && in_ready;
    outf = out_valid && out_ready;
    if (out_valid && q.size() > 0) begin
      check("out_word", pk_out(), q[0]);
      if (outf) void'(q.pop_front());
    end
    if (inf) begin
      w = model(instr, rs1_data, rs2_data);
      q.push_back(w);
      if (!out_valid || out_ready) lat_chk = 1'b1;
      if (w[0] && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    end
    last_inf = inf;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    instr    = ins;
    rs1_data = r1;
    rs2_data = r2;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_inf) break;
    end
    check("send_accepted", 74'(last_inf), 74'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) cycle();
    check("drain_empty", 74'(q.size()), 74'(0));
  endtask

  logic [31:0] b2b_ins[4];
  logic [31:0] b2b_rs1[4];
  int          idx;
  int          fired;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rs1_data = '0; rs2_data = '0;
    cnt_m = '0; lat_chk = 1'b0; dir_en = 1'b0; last_inf = 1'b0; dir_exp = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_out_valid", 74'(out_valid), 74'(0));
    check("reset_outputs", pk_out(), 74'(0));
    check("reset_cnt", 74'(illegal_cnt), 74'(0));
`ifdef ALU_ISSUE_SKID_EN
    check("reset_in_ready", 74'(in_ready), 74'(0));
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", 74'(in_ready), 74'(1));
    out_ready = 1'b1;

    // Directed words
    send(r_type(7'h00, 3'b000), 32'd5, 32'd7);
    dir_exp = {4'd0, 5'd0, 32'd5, 32'd7, 1'b0}; dir_en = 1'b1; cycle();
    send(r_type(7'h20, 3'b000), 32'd10, 32'd3);
    dir_exp = {4'd1, 5'd0, 32'd3, 32'd10, 1'b0}; dir_en = 1'b1; cycle();
    send(i_type(12'h404, 3'b101), 32'h8000_0000, 32'h0000_1234);
    dir_exp = {4'd9, 5'd4, 32'h8000_0000, 32'd0, 1'b0}; dir_en = 1'b1; cycle();
    send(i_type(12'hFFF, 3'b000), 32'd1, 32'd9);
    dir_exp = {4'd0, 5'd0, 32'd1, 32'hFFFF_FFFF, 1'b0}; dir_en = 1'b1; cycle();
    send(i_type(12'h403, 3'b001), 32'd6, 32'd8);
    dir_exp = {4'd0, 5'd0, 32'd0, 32'd0, 1'b1}; dir_en = 1'b1; cycle();
    check("cnt_after_slli", 74'(illegal_cnt), 74'(1));
    drain();

    // Back-to-back four words with a three-cycle downstream stall mid-stream
    b2b_ins[0] = r_type(7'h00, 3'b100); b2b_rs1[0] = 32'hA;
    b2b_ins[1] = r_type(7'h00, 3'b110); b2b_rs1[1] = 32'hB;
    b2b_ins[2] = r_type(7'h00, 3'b001); b2b_rs1[2] = 32'hC;
    b2b_ins[3] = r_type(7'h20, 3'b000); b2b_rs1[3] = 32'hD;
    idx = 0;
    for (int t = 0; t < 14; t++) begin
      out_ready = !(t >= 2 && t < 5);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        instr    = b2b_ins[idx];
        rs1_data = b2b_rs1[idx];
        rs2_data = 32'h100 + 32'(idx);
      end
      cycle();
      if (last_inf) idx++;
    end
    check("b2b_all_accepted", 74'(idx), 74'(4));
    drain();

    // Randomized traffic against the model
    repeat (800) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = rand_instr();
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      cycle();
    end
    drain();

    // Saturation of the illegal counter with branch opcodes
    instr = 32'h0000_0063; rs1_data = 32'd0; rs2_data = 32'd0;
    in_valid = 1'b1; out_ready = 1'b1; fired = 0;
    for (int k = 0; k < 70000 && fired < 65537; k++) begin
      cycle();
      if (last_inf) fired++;
    end
    in_valid = 1'b0;
    check("sat_fires", 74'(fired), 74'(65537));
    check("cnt_saturated", 74'(illegal_cnt), 74'(16'hFFFF));
    drain();

    // Reset while a word is held by a stalled output
    out_ready = 1'b0;
    send(r_type(7'h00, 3'b111), 32'h1, 32'h2);
    cycle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_out_valid", 74'(out_valid), 74'(0));
    check("midreset_outputs", pk_out(), 74'(0));
    check("midreset_cnt", 74'(illegal_cnt), 74'(0));
    q.delete();
    cnt_m = '0;
    lat_chk = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(r_type(7'h00, 3'b010), 32'd3, 32'd4);
    dir_exp = {4'd2, 5'd0, 32'd3, 32'd4, 1'b0}; dir_en = 1'b1; cycle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
